led_flow_monitor: RTL and testbench

Passive observer on the flowing-LED bus: samples the `led` vector that the `leds` driver produces, locks onto the one-hot rotation, and flags pattern, step and timing violations. It is the receive/check end of the LED interface. It sits beside `leds` in the board top and in benches as a self-checking sink. Outputs feed debug LEDs/7-seg and bench assertions.

---
 rtl/led_flow_pkg.sv | 32 +++
 rtl/led_flow_monitor_sync.sv | 23 ++
 rtl/led_flow_monitor.sv | 171 +++++++++++++++++
 tb/tb_led_flow_monitor.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_flow_pkg.sv
// led_flow_pkg: shared state type, error codes and one-hot helpers for led_flow_monitor.
// Helpers take a fixed-width vector; callers zero-extend buses of up to MAX_W bits.
package led_flow_pkg;

    localparam int LED_W_DEFAULT = 10;
    localparam int MAX_W         = 64;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_PATTERN = 2'd1;
    localparam logic [1:0] ERR_STEP    = 2'd2;
    localparam logic [1:0] ERR_TIMING  = 2'd3;

    function automatic logic is_onehot(input logic [MAX_W-1:0] v);
        return (v != '0) && ((v & (v - MAX_W'(1))) == '0);
    endfunction

    function automatic logic [5:0] onehot_index(input logic [MAX_W-1:0] v);
        logic [5:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (v[i]) idx = 6'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/led_flow_monitor_sync.sv
// led_sync: parameterized-width two-flop synchronizer with asynchronous active-high clear.
module led_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/led_flow_monitor.sv
// led_flow_monitor: passive checker that locks onto the one-hot LED rotation and flags errors.
// Optional: define LED_FLOW_MON_BOUNCE_EN to accept a reversal at either end position.
module led_flow_monitor
    import led_flow_pkg::*;
#(
    parameter int LED_W       = LED_W_DEFAULT,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int TOL         = 1000
) (
    input  logic                     clk_50M,
    input  logic                     reset,
    input  logic [LED_W-1:0]         led,
    output logic                     locked,
    output logic                     dir,
    output logic [$clog2(LED_W)-1:0] pos,
    output logic [15:0]              step_count,
    output logic                     err_pulse,
    output logic [1:0]               err_code,
    output logic [7:0]               err_count
);

    localparam int PW      = $clog2(LED_W);
    localparam int CNT_MAX = STEP_CYCLES + TOL + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // cnt holds cycles since the last change minus one, so the window is shifted by one
    localparam logic [CW-1:0] CNT_SAT  = CW'(CNT_MAX);
    localparam logic [CW-1:0] CNT_LO   = CW'(STEP_CYCLES - TOL - 1);
    localparam logic [CW-1:0] CNT_HI   = CW'(STEP_CYCLES + TOL - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(LED_W - 1);

    logic [LED_W-1:0] s2;
    logic [LED_W-1:0] led_q;
    logic             change;
    logic             s2_hot;
    logic [PW-1:0]    s2_idx;
    logic [PW-1:0]    pos_up;
    logic [PW-1:0]    pos_dn;
    logic [PW-1:0]    fwd_idx;
    logic             bounce_ok;
    logic [CW-1:0]    cnt;
    logic             cnt_sat;
    logic             interval_ok;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] pos_nx;
    logic          dir_nx;
    logic          step_inc;
    logic          err_det;
    logic [1:0]    err_sel;
    logic          load_clr;

    led_sync #(.W(LED_W)) u_sync (
        .clk (clk_50M),
        .rst (reset),
        .d   (led),
        .q   (s2)
    );

    assign change      = (s2 != led_q);
    assign s2_hot      = is_onehot(MAX_W'(s2));
    assign s2_idx      = PW'(onehot_index(MAX_W'(s2)));
    assign pos_up      = (pos == POS_LAST) ? '0 : pos + PW'(1);
    assign pos_dn      = (pos == '0) ? POS_LAST : pos - PW'(1);
    assign fwd_idx     = dir ? pos_up : pos_dn;
    assign cnt_sat     = (cnt == CNT_SAT);
    assign interval_ok = (cnt >= CNT_LO) && (cnt <= CNT_HI);

`ifdef LED_FLOW_MON_BOUNCE_EN
    logic [PW-1:0] rev_idx;
    assign rev_idx   = dir ? pos_dn : pos_up;
    assign bounce_ok = ((pos == '0) || (pos == POS_LAST)) && (s2_idx == rev_idx);
`else
    assign bounce_ok = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        pos_nx   = pos;
        dir_nx   = dir;
        step_inc = 1'b0;
        err_det  = 1'b0;
        err_sel  = ERR_NONE;
        load_clr = 1'b0;
        case (state)
            IDLE: begin
                if (s2_hot) begin
                    pos_nx   = s2_idx;
                    load_clr = 1'b1;
                    state_nx = ACQUIRE;
                end
            end
            ACQUIRE: begin
                if (change) begin
                    if (!s2_hot) begin
                        err_det = 1'b1;
                        err_sel = ERR_PATTERN;
                    end else if (s2_idx == pos_up || s2_idx == pos_dn) begin
                        dir_nx   = (s2_idx == pos_up);
                        pos_nx   = s2_idx;
                        step_inc = 1'b1;
                        state_nx = TRACK;
                    end else begin
                        err_det = 1'b1;
                        err_sel = ERR_STEP;
                    end
                end else if (cnt_sat) begin
                    err_det = 1'b1;
                    err_sel = ERR_TIMING;
                end
            end
            TRACK: begin
                if (change) begin
                    if (!s2_hot) begin
                        err_det = 1'b1;
                        err_sel = ERR_PATTERN;
                    end else if (s2_idx != fwd_idx && !bounce_ok) begin
                        err_det = 1'b1;
                        err_sel = ERR_STEP;
                    end else if (!interval_ok) begin
                        err_det = 1'b1;
                        err_sel = ERR_TIMING;
                    end else begin
                        pos_nx   = s2_idx;
                        dir_nx   = bounce_ok ? ~dir : dir;
                        step_inc = 1'b1;
                    end
                end else if (cnt_sat) begin
                    err_det = 1'b1;
                    err_sel = ERR_TIMING;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (err_det) state_nx = IDLE;
    end

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            led_q      <= '0;
            cnt        <= '0;
            locked     <= 1'b0;
            dir        <= 1'b0;
            pos        <= '0;
            step_count <= '0;
            err_pulse  <= 1'b0;
            err_code   <= ERR_NONE;
            err_count  <= '0;
        end else begin
            state  <= state_nx;
            led_q  <= s2;
            if (change || load_clr) begin
                cnt <= '0;
            end else if (!cnt_sat) begin
                cnt <= cnt + CW'(1);
            end
            locked <= (state_nx == TRACK);
            dir    <= dir_nx;
            pos    <= pos_nx;
            if (step_inc) step_count <= step_count + 16'd1;
            err_pulse <= err_det;
            if (err_det) begin
                err_code <= err_sel;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_led_flow_monitor.sv
// tb_led_flow_monitor: directed and random LED sequences against an index-level reference model.
// Expected step/error events are queued at stimulus time and matched by an independent monitor.
module tb_led_flow_monitor;

    localparam int W   = 10;
    localparam int S   = 8;
    localparam int T   = 1;
    localparam int SAT = S + T + 1;
`ifdef LED_FLOW_MON_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] led   = '0;
    logic         locked;
    logic         dir;
    logic [3:0]   pos;
    logic [15:0]  step_count;
    logic         err_pulse;
    logic [1:0]   err_code;
    logic [7:0]   err_count;

    led_flow_monitor #(.LED_W(W), .STEP_CYCLES(S), .TOL(T)) dut (
        .clk_50M    (clk),
        .reset      (reset),
        .led        (led),
        .locked     (locked),
        .dir        (dir),
        .pos        (pos),
        .step_count (step_count),
        .err_pulse  (err_pulse),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_err;
        int code;
        int pos;
        bit dir;
        int steps;
        int errs;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    // reference model: mode 0 idle, 1 acquiring, 2 tracking
    int           m_mode  = 0;
    int           m_pos   = 0;
    bit           m_dir   = 1'b0;
    int           m_steps = 0;
    int           m_errs  = 0;
    logic [W-1:0] m_cur   = '0;
    int           last_cyc = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int hot_idx(input logic [W-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < W; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] hot(input int i);
        logic [W-1:0] x;
        x    = '0;
        x[i] = 1'b1;
        return x;
    endfunction

    task automatic m_error(input int code);
        if (m_errs < 255) m_errs++;
        exp_q.push_back('{1'b1, code, m_pos, m_dir, m_steps, m_errs});
        m_mode = 0;
    endtask

    task automatic m_step(input int k, input bit d);
        m_pos   = k;
        m_dir   = d;
        m_steps = (m_steps + 1) % 65536;
        m_mode  = 2;
        exp_q.push_back('{1'b0, 0, k, d, m_steps, m_errs});
    endtask

    task automatic m_idle_look(input logic [W-1:0] v);
        if (m_mode == 0 && hot_idx(v) >= 0) begin
            m_mode = 1;
            m_pos  = hot_idx(v);
        end
    endtask

    // v replaces m_cur after h clock cycles
    task automatic m_change(input logic [W-1:0] v, input int h);
        int k, fwd, rev;
        bit bnc;
        k = hot_idx(v);
        if (m_mode == 2 && h > SAT + 1) begin
            m_error(3);
            m_idle_look(m_cur);
        end
        if (m_mode == 0) begin
            m_idle_look(v);
        end else if (m_mode == 1) begin
            if (k < 0)                      m_error(1);
            else if (k == (m_pos + 1) % W)  m_step(k, 1'b1);
            else if (k == (m_pos + W - 1) % W) m_step(k, 1'b0);
            else                            m_error(2);
        end else begin
            fwd = m_dir ? (m_pos + 1) % W : (m_pos + W - 1) % W;
            rev = m_dir ? (m_pos + W - 1) % W : (m_pos + 1) % W;
            bnc = BOUNCE && (m_pos == 0 || m_pos == W - 1) && (k == rev);
            if (k < 0)                        m_error(1);
            else if (k != fwd && !bnc)        m_error(2);
            else if (h < S - T || h > S + T)  m_error(3);
            else                              m_step(k, bnc ? !m_dir : m_dir);
        end
        m_idle_look(v);
        m_cur = v;
    endtask

    task automatic drive(input logic [W-1:0] v, input int h);
        m_change(v, h);
        while (cyc < last_cyc + h) @(negedge clk);
        led      = v;
        last_cyc = cyc;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_dir"}, dir, 0);
        check({tag, "_pos"}, pos, 0);
        check({tag, "_step_count"}, step_count, 0);
        check({tag, "_err_pulse"}, err_pulse, 0);
        check({tag, "_err_code"}, err_code, 0);
        check({tag, "_err_count"}, err_count, 0);
    endtask

    logic [15:0] prev_steps = '0;

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            prev_steps = '0;
        end else begin
            if (err_pulse) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_error: got code %0d, expected no event", err_code);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_err", 1, e.is_err);
                    check("err_code", err_code, e.code);
                    check("err_count", err_count, e.errs);
                    check("locked_after_err", locked, 0);
                end
            end
            if (step_count != prev_steps) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_step: got step_count %0d, expected no event", step_count);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_step", 0, e.is_err);
                    check("step_count", step_count, e.steps);
                    check("step_pos", pos, e.pos);
                    check("step_dir", dir, e.dir);
                    check("locked_after_step", locked, 1);
                end
                prev_steps = step_count;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected finish earlier");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wait_neg(3);
        check_all_zero("reset");
        reset    = 1'b0;
        last_cyc = cyc;

        // rotation with 9->0 wrap: 13 values, 12 accepted steps
        for (int i = 0; i < 13; i++) drive(hot(i % W), S);
        wait_neg(4);
        check("rot_step_count", step_count, 12);
        check("rot_locked", locked, 1);
        check("rot_dir", dir, 1);
        check("rot_pos", pos, 2);
        check("rot_err_count", err_count, 0);

        drive(10'h003, S);      // pattern error
        drive(10'h004, S);
        drive(10'h008, S);
        drive(10'h010, S);
        drive(10'h040, S);      // skipped position
        drive(10'h080, S);
        drive(10'h100, S);
        drive(10'h200, S - 2);  // early step
        drive(10'h001, S);
        drive(10'h002, S);
        drive(10'h004, SAT + 3); // stall then relock
        for (int i = 3; i < W; i++) drive(hot(i), S);
        drive(10'h100, S);      // reversal at the top end
        drive(10'h080, S);
        wait_neg(4);
        check("directed_err_count", err_count, m_errs);
        check("directed_queue_empty", exp_q.size(), 0);

        // asynchronous reset in the middle of a step
        @(posedge clk);
        #2;
        reset = 1'b1;
        led   = '0;
        #1;
        check_all_zero("async_reset");
        m_mode  = 0;
        m_pos   = 0;
        m_dir   = 1'b0;
        m_steps = 0;
        m_errs  = 0;
        m_cur   = '0;
        exp_q.delete();
        wait_neg(3);
        reset    = 1'b0;
        last_cyc = cyc;
        drive(10'h010, 3);
        drive(10'h020, S);
        drive(10'h040, S);
        wait_neg(4);
        check("relock_locked", locked, 1);
        check("relock_err_count", err_count, 0);
        check("relock_step_count", step_count, 2);

        for (int i = 0; i < 150; i++) begin
            int r, k, base, st, h;
            logic [W-1:0] v;
            r    = int'($urandom_range(0, 99));
            k    = hot_idx(m_cur);
            base = (k < 0) ? int'($urandom_range(0, W - 1)) : k;
            st   = m_dir ? 1 : W - 1;
            v    = hot((base + st) % W);
            h    = int'($urandom_range(S - T, S + T));
            if (r < 8)       h = int'($urandom_range(3, S - T - 1));
            else if (r < 12) h = int'($urandom_range(S + T + 1, SAT + 1));
            else if (r < 18) v = m_cur ^ hot(int'($urandom_range(0, W - 1)));
            else if (r < 22) v = hot((base + 2 * st) % W);
            else if (r < 26) v = hot((base + W - st) % W);
            else if (r < 30 && m_mode == 2) h = SAT + 3 + int'($urandom_range(0, 1));
            drive(v, h);
        end
        wait_neg(5);
        check("final_queue_empty", exp_q.size(), 0);
        check("final_step_count", step_count, m_steps);
        check("final_err_count", err_count, m_errs);
        check("final_locked", locked, (m_mode == 2) ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
